// File: rtl/picomips_pkg.sv
// Shared constants and types for the picoMIPS datapath blocks.
// The multiply/write-back unit imports these.
package picomips_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;

  // Largest positive Q1.7 value, returned when -1.0 * -1.0 overflows.
  localparam logic [DATA_WIDTH-1:0] FRAC_SAT_POS = 8'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_wb_unit_chk.sv
// Protocol checker for mul_wb_unit.
// It watches the FSM state, the counter and the write-back strobes.
module mul_wb_unit_chk
  import picomips_pkg::*;
#(
  parameter int CNT_WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  input mul_state_t           state,
  input logic [CNT_WIDTH-1:0] cnt,
  input logic                 busy,
  input logic                 done,
  input logic                 w
);

  // Write strobe and done pulse are the same event.
  a_w_is_done: assert property (@(posedge clk) w == done);

  // A write can only happen while the unit reports busy.
  a_w_implies_busy: assert property (@(posedge clk) w |-> busy);

  // Write-back lasts exactly one cycle.
  a_wb_single: assert property (@(posedge clk) disable iff (reset)
    (state == WB) |=> (state == IDLE));

  // The iteration counter is never exhausted while still calculating.
  a_calc_cnt: assert property (@(posedge clk) disable iff (reset)
    (state == CALC) |-> (cnt != '0));

endmodule

// File: rtl/mul_wb_unit.sv
// Sequential signed shift-add multiplier feeding the register-file write port.
// It works in sign-magnitude form, with one radix-2 step per cycle and a final negate.
module mul_wb_unit
  import picomips_pkg::*;
#(
  parameter int DATA_WIDTH = picomips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = picomips_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  frac,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [ADDR_WIDTH-1:0] dest,
  output logic                  busy,
  output logic                  done,
  output logic                  w,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] SAT_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  // The most negative value maps to its unsigned magnitude (e.g. 0x80 -> 128).
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] m;
    if (v[DATA_WIDTH-1]) begin
      m = ~v + DATA_WIDTH'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Fractional mode overflows only when the top two product bits disagree (-1.0 * -1.0).
  function automatic logic [DATA_WIDTH-1:0] pick_result(input logic [PROD_WIDTH-1:0] p,
                                                        input logic                  frac_mode);
    logic [DATA_WIDTH-1:0] r;
    if (frac_mode) begin
      if (p[PROD_WIDTH-1] != p[PROD_WIDTH-2]) begin
        r = SAT_POS;
      end else begin
        r = p[PROD_WIDTH-2:DATA_WIDTH-1];
      end
    end else begin
      r = p[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  mul_state_t             state_r, state_s;
  logic [PROD_WIDTH-1:0]  acc_r, acc_s;
  logic [PROD_WIDTH-1:0]  mcand_r, mcand_s;
  logic [DATA_WIDTH-1:0]  mplier_r, mplier_s;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
  logic                   neg_r, neg_s;
  logic                   frac_r, frac_s;
  logic [ADDR_WIDTH-1:0]  dest_r, dest_s;
  logic [ADDR_WIDTH-1:0]  waddr_r, waddr_s;
  logic [DATA_WIDTH-1:0]  wdata_r, wdata_s;

  logic [PROD_WIDTH-1:0]  acc_step_s;
  logic [PROD_WIDTH-1:0]  prod_s;

  assign acc_step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign prod_s     = neg_r ? (~acc_step_s + PROD_WIDTH'(1)) : acc_step_s;

  // Next-state and datapath update for the IDLE/CALC/WB sequence.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    cnt_s    = cnt_r;
    neg_s    = neg_r;
    frac_s   = frac_r;
    dest_s   = dest_r;
    waddr_s  = waddr_r;
    wdata_s  = wdata_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = CALC;
          acc_s    = '0;
          mcand_s  = {{DATA_WIDTH{1'b0}}, magnitude(op_a)};
          mplier_s = magnitude(op_b);
          cnt_s    = CNT_LOAD;
          neg_s    = op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
          frac_s   = frac;
          dest_s   = dest;
        end else begin
          state_s  = IDLE;
        end
      end
      CALC: begin
        acc_s    = acc_step_s;
        mcand_s  = {mcand_r[PROD_WIDTH-2:0], 1'b0};
        mplier_s = {1'b0, mplier_r[DATA_WIDTH-1:1]};
        cnt_s    = cnt_r - CNT_ONE;
        // The last step's sum is signed and formatted on the way into the write registers.
        if (cnt_r == CNT_ONE) begin
          state_s = WB;
          waddr_s = dest_r;
          wdata_s = pick_result(prod_s, frac_r);
        end else begin
          state_s = CALC;
        end
      end
      WB: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
      frac_r   <= 1'b0;
      dest_r   <= '0;
      waddr_r  <= '0;
      wdata_r  <= '0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      cnt_r    <= cnt_s;
      neg_r    <= neg_s;
      frac_r   <= frac_s;
      dest_r   <= dest_s;
      waddr_r  <= waddr_s;
      wdata_r  <= wdata_s;
    end
  end

  assign busy  = (state_r != IDLE);
  assign w     = (state_r == WB);
  assign done  = (state_r == WB);
  assign waddr = waddr_r;
  assign wdata = wdata_r;

  mul_wb_unit_chk #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .state (state_r),
    .cnt   (cnt_r),
    .busy  (busy),
    .done  (done),
    .w     (w)
  );

endmodule

// File: tb/tb_mul_wb_unit.sv
// Directed self-checking bench for mul_wb_unit.
// Expected results are hand-computed signed products.
module tb_mul_wb_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       frac;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] dest;
  logic       busy;
  logic       done;
  logic       w;
  logic [1:0] waddr;
  logic [7:0] wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Write-back log, filled only by the negedge monitor
  int         w_count = 0;
  int         w_cyc [64];
  logic [7:0] w_dat;
  logic [1:0] w_adr;

  mul_wb_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .frac  (frac),
    .op_a  (op_a),
    .op_b  (op_b),
    .dest  (dest),
    .busy  (busy),
    .done  (done),
    .w     (w),
    .waddr (waddr),
    .wdata (wdata)
  );

  always #5 clk = ~clk;

  // Record every write-back mid-cycle
  always @(negedge clk) begin
    if (w) begin
      if (w_count < 64) w_cyc[w_count] = cyc;
      w_count = w_count + 1;
      w_dat   = wdata;
      w_adr   = waddr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // Start in cycle 0, expect the single write in cycle 9
  task automatic run_op(input string tag, input logic f, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] d, input logic [7:0] exp);
    int base;
    base = w_count;
    cyc = 0;
    frac = f; op_a = a; op_b = b; dest = d; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    check({tag, "_nw"},   32'(w_count - base), 32'd1);
    check({tag, "_cyc"},  32'(w_cyc[base]), 32'd9);
    check({tag, "_data"}, 32'(w_dat), 32'(exp));
    check({tag, "_addr"}, 32'(w_adr), 32'(d));
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; frac = 1'b0;
    op_a = 8'h00; op_b = 8'h00; dest = 2'd0;
    step();
    step();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_w",     32'(w),     32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    reset = 1'b0;
    step();

    // 0.5 * 0.5 with a per-cycle view of busy/w/done
    base = w_count;
    cyc = 0;
    frac = 1'b1; op_a = 8'h40; op_b = 8'h40; dest = 2'd2; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) start = 1'b0;
      check($sformatf("t1_busy_c%0d", c), 32'(busy), (c <= 9) ? 32'd1 : 32'd0);
      check($sformatf("t1_w_c%0d", c),    32'(w),    (c == 9) ? 32'd1 : 32'd0);
      check($sformatf("t1_done_c%0d", c), 32'(done), (c == 9) ? 32'd1 : 32'd0);
    end
    check("t1_nw",    32'(w_count - base), 32'd1);
    check("t1_data",  32'(w_dat), 32'h20);
    check("t1_addr",  32'(w_adr), 32'd2);
    check("t1_hold",  32'(wdata), 32'h20);

    run_op("neg_half",  1'b1, 8'hC0, 8'h40, 2'd1, 8'hE0);
    run_op("sat",       1'b1, 8'h80, 8'h80, 2'd3, 8'h7F);
    run_op("int_neg",   1'b0, 8'h05, 8'hFD, 2'd0, 8'hF1);
    run_op("int_wrap",  1'b0, 8'h10, 8'h10, 2'd2, 8'h00);
    run_op("frac_floor",1'b1, 8'h01, 8'hFF, 2'd1, 8'hFF);
    run_op("frac_max",  1'b1, 8'h7F, 8'h7F, 2'd0, 8'h7E);
    run_op("frac_m1",   1'b1, 8'h80, 8'h7F, 2'd3, 8'h81);
    run_op("frac_mix",  1'b1, 8'h60, 8'hA0, 2'd2, 8'hB8);
    run_op("int_min",   1'b0, 8'h80, 8'h01, 2'd1, 8'h80);
    run_op("int_minsq", 1'b0, 8'h80, 8'h80, 2'd0, 8'h00);
    run_op("zero",      1'b0, 8'h00, 8'h7F, 2'd3, 8'h00);

    // Starts during CALC and WB are ignored; the one in cycle 10 is taken
    base = w_count;
    cyc = 0;
    frac = 1'b0; op_a = 8'h05; op_b = 8'hFD; dest = 2'd1; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        start = 1'b1; frac = 1'b1; op_a = 8'h7F; op_b = 8'h7F; dest = 2'd3;
      end
      if (c == 4) start = 1'b0;
      if (c == 9) begin
        start = 1'b1; frac = 1'b0; op_a = 8'h03; op_b = 8'h04; dest = 2'd0;
      end
      if (c == 10) begin
        check("ign_nw",   32'(w_count - base), 32'd1);
        check("ign_cyc",  32'(w_cyc[base]), 32'd9);
        check("ign_data", 32'(w_dat), 32'hF1);
        check("ign_addr", 32'(w_adr), 32'd1);
      end
      if (c == 11) begin
        start = 1'b0;
        check("ign_acc_busy", 32'(busy), 32'd1);
      end
    end
    check("ign2_nw",   32'(w_count - base), 32'd2);
    check("ign2_cyc",  32'(w_cyc[base + 1]), 32'd19);
    check("ign2_data", 32'(w_dat), 32'h0C);
    check("ign2_addr", 32'(w_adr), 32'd0);

    // Reset in cycle 4 of CALC aborts the operation
    base = w_count;
    cyc = 0;
    frac = 1'b0; op_a = 8'h07; op_b = 8'h03; dest = 2'd1; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) step();
    check("abort_nw",   32'(w_count - base), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    run_op("after_rst", 1'b0, 8'h07, 8'h03, 2'd1, 8'h15);

    // start and reset together: reset wins
    frac = 1'b0; op_a = 8'h02; op_b = 8'h02; dest = 2'd2;
    reset = 1'b1; start = 1'b1;
    step();
    check("rst_start_busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    step();
    check("rst_start_idle", 32'(busy), 32'd0);

    // start held high: one acceptance every 10 cycles
    base = w_count;
    cyc = 0;
    frac = 1'b1; op_a = 8'hC0; op_b = 8'h40; dest = 2'd3; start = 1'b1;
    for (int c = 1; c <= 30; c++) step();
    start = 1'b0;
    check("b2b_nw",   32'(w_count - base), 32'd3);
    check("b2b_cyc0", 32'(w_cyc[base]), 32'd9);
    check("b2b_cyc1", 32'(w_cyc[base + 1]), 32'd19);
    check("b2b_cyc2", 32'(w_cyc[base + 2]), 32'd29);
    check("b2b_data", 32'(w_dat), 32'hE0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_wb_unit.md
Name: mul_wb_unit

Overview:
- Sequential signed 8x8 shift-add multiplier that sits directly downstream of the register-file read ports (data1_q/data2_q) and upstream of its write port (w/waddr/wdata).
- Controller pulses start with both operands and a destination register. The unit computes over DATA_WIDTH cycles, then issues exactly one register write-back with a done pulse.
- Supports Q1.7 fractional mode (affine-transform coefficients) and integer low-byte mode.

Parameters:
- DATA_WIDTH, 8, operand, result and write-data width.
- ADDR_WIDTH, 2, register address width; matches the register file.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- frac  in  1  1 = Q1.7 fractional result, 0 = integer low byte; latched at start.
- op_a  in  DATA_WIDTH  signed multiplicand (from data1_q); latched at start.
- op_b  in  DATA_WIDTH  signed multiplier (from data2_q); latched at start.
- dest  in  ADDR_WIDTH  write-back register index; latched at start.
- busy  out  1  high from the cycle after start acceptance through the WB cycle inclusive.
- done  out  1  one-cycle pulse, coincident with w.
- w  out  1  register-file write enable; one-cycle pulse.
- waddr  out  ADDR_WIDTH  write address (latched dest).
- wdata  out  DATA_WIDTH  result byte.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Everything, including reset, acts on the rising edge of clk.
- States (registered): IDLE, CALC, WB.
  - IDLE -> CALC when start=1: latch op_a, op_b, frac, dest; clear the accumulator; load the iteration counter with DATA_WIDTH.
  - CALC: each cycle, one radix-2 step (add shifted multiplicand if the current multiplier bit is set; shift; decrement the counter). Two's-complement signed operation: Baugh-Wooley, or sign-magnitude with a final negate.
  - CALC -> WB when the counter reaches 0 after exactly DATA_WIDTH CALC cycles.
  - WB -> IDLE unconditionally.
- Outputs are decoded from the registered state and registers only; no combinational path from inputs.
  - w = done = (state==WB).
  - busy = (state!=IDLE).
- Latency: start high in cycle 0 -> CALC cycles 1..DATA_WIDTH -> w/done high in cycle DATA_WIDTH+1 (cycle 9 at default) for exactly one cycle. Next start is accepted at the earliest in cycle DATA_WIDTH+2.
- Arithmetic: P = exact 2*DATA_WIDTH-bit signed product of op_a and op_b.
  - frac=0: wdata = P[DATA_WIDTH-1:0] (wraps silently).
  - frac=1: wdata = P[2*DATA_WIDTH-2 : DATA_WIDTH-1]. This truncates toward negative infinity.
  - Single overflow case, op_a = op_b = most negative value (-1.0 * -1.0): saturate to 0x7F (the maximum positive value).
- waddr/wdata hold their last values outside WB. w=0 outside WB.
- Boundary conditions:
  - start while busy (including during WB): ignored, with no queuing.
  - op_a, op_b, dest, frac changing after acceptance: no effect.
  - Zero operand: still takes the full DATA_WIDTH cycles; no early termination.
  - reset=1 in any state (including mid-CALC or during WB): next state IDLE. The in-flight operation is aborted and produces no write.
  - Reset values: busy=0, done=0, w=0, waddr=0, wdata=0; accumulator and counter 0.
  - start and reset high together: reset wins.

Decomposition:
- Shared package picomips_pkg:
  - DATA_WIDTH and ADDR_WIDTH constants.
  - mul_state_t enum {IDLE, CALC, WB}.
  - FRAC_SAT_POS constant (0x7F).
- Single module; no sub-module is needed. The datapath (accumulator, shifter, counter) and the FSM fit in one file of roughly 150-200 lines.

Test Plan:
- frac=1, op_a=0x40, op_b=0x40 (0.5*0.5), dest=2 -> w=1 only in cycle 9 after start, waddr=2, wdata=0x20, done pulse 1 cycle, busy high cycles 1-9.
- frac=1, op_a=0xC0, op_b=0x40 (-0.5*0.5) -> wdata=0xE0; frac=1, op_a=0x80, op_b=0x80 -> wdata=0x7F (saturated).
- frac=0, op_a=0x05, op_b=0xFD (5*-3) -> wdata=0xF1; frac=0, op_a=0x10, op_b=0x10 -> wdata=0x00 (wrap).
- start pulses in cycles 3 and 9 of an active operation, with operands changed after acceptance -> exactly one write, with the original operands' result; next start in cycle 10 is accepted.
- reset asserted in cycle 4 of CALC -> busy=0 next cycle, no w pulse for 12 cycles; a new start after reset completes normally.
- Back-to-back starts, with start held high continuously -> writes in cycles 9, 19, 29 (a new acceptance every DATA_WIDTH+2 cycles).
